// File: rtl/dvi_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : dvi_frame_reader_if
// Brief    : Read-FIFO handshake and DVI video bundle for dvi_frame_reader.
//            master = frame reader side, slave = FIFO / transmitter side.
// Revision : 1.0 - initial release
// ============================================================================
interface dvi_frame_reader_if;
    logic        enable;
    logic        read_init;
    logic        fifo_rdreq;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic [8:0]  fifo_rdusedw;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        frame_start;
    logic        underflow;

    modport master (
        input  enable, fifo_q, fifo_empty, fifo_rdusedw,
        output read_init, fifo_rdreq, hsync, vsync, de, r, g, b,
               frame_start, underflow
    );

    modport slave (
        output enable, fifo_q, fifo_empty, fifo_rdusedw,
        input  read_init, fifo_rdreq, hsync, vsync, de, r, g, b,
               frame_start, underflow
    );
endinterface
`default_nettype wire

// File: rtl/dvi_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : dvi_frame_reader
// Brief    : Pops the frame-buffer read FIFO once per active pixel and drives
//            RGB888 + hsync/vsync/de. Timing never stalls; FIFO underflow
//            produces black pixels and a sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module dvi_frame_reader #(
    parameter int   H_ACTIVE    = 320,
    parameter int   H_FP        = 8,
    parameter int   H_SYNC      = 32,
    parameter int   H_BP        = 40,
    parameter int   V_ACTIVE    = 240,
    parameter int   V_FP        = 3,
    parameter int   V_SYNC      = 4,
    parameter int   V_BP        = 6,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   PRIME_LEVEL = 64
) (
    input  wire logic           dvi_clk,
    input  wire logic           reset,
    dvi_frame_reader_if.master  bus
);
    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int C_HW      = $clog2(C_H_TOTAL);
    localparam int C_VW      = $clog2(C_V_TOTAL);

    localparam logic [C_HW-1:0] C_H_LAST   = C_HW'(C_H_TOTAL - 1);
    localparam logic [C_HW-1:0] C_H_ACT    = C_HW'(H_ACTIVE);
    localparam logic [C_HW-1:0] C_HS_START = C_HW'(H_ACTIVE + H_FP);
    localparam logic [C_HW-1:0] C_HS_END   = C_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [C_VW-1:0] C_V_LAST   = C_VW'(C_V_TOTAL - 1);
    localparam logic [C_VW-1:0] C_V_ACT    = C_VW'(V_ACTIVE);
    localparam logic [C_VW-1:0] C_VS_START = C_VW'(V_ACTIVE + V_FP);
    localparam logic [C_VW-1:0] C_VS_END   = C_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0]      C_PRIME    = 9'(PRIME_LEVEL);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_PRIME = 2'd1;
    localparam logic [1:0] C_ST_RUN   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [C_HW-1:0] h_cnt_q, h_cnt_d;
    logic [C_VW-1:0] v_cnt_q, v_cnt_d;

    // Stage 0 combinational decode of the counter position
    logic w_run, w_active, w_rdreq, w_read_init, w_hs0, w_vs0, w_fs0;

    // Stage 1 (FIFO data valid) and stage 2 (output pins)
    logic        de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic        fs_s1_q, fs_s1_d, pop_s1_q, pop_s1_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;
    logic        underflow_q, underflow_d;

    // Top byte of each FIFO word carries no pixel data
    logic [7:0]  w_unused_fifo_hi;
    assign w_unused_fifo_hi = bus.fifo_q[31:24];

    // State and raster counter registers
    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Next state and counter advance; counters sit at 0 outside RUN so RUN starts at (0,0)
    always_comb begin
        state_d = state_q;
        h_cnt_d = '0;
        v_cnt_d = '0;
        case (state_q)
            C_ST_IDLE: begin
                if (bus.enable) state_d = C_ST_PRIME;
            end
            C_ST_PRIME: begin
                if (bus.fifo_rdusedw >= C_PRIME) state_d = C_ST_RUN;
            end
            C_ST_RUN: begin
                h_cnt_d = h_cnt_q + 1'b1;
                v_cnt_d = v_cnt_q;
                if (h_cnt_q == C_H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == C_V_LAST) begin
                        // enable only matters here, so a started frame always completes
                        v_cnt_d = '0;
                        if (!bus.enable) state_d = C_ST_IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // FSM outputs and stage-0 raster decode
    always_comb begin
        w_run       = (state_q == C_ST_RUN);
        w_read_init = (state_q != C_ST_IDLE);
        w_active    = w_run && (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);
        w_rdreq     = w_active && !bus.fifo_empty;
        w_hs0       = w_run && (h_cnt_q >= C_HS_START) && (h_cnt_q < C_HS_END);
        w_vs0       = w_run && (v_cnt_q >= C_VS_START) && (v_cnt_q < C_VS_END);
        w_fs0       = w_run && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Pipeline next values: controls delayed two cycles to meet the FIFO data
    always_comb begin
        de_s1_d     = w_active;
        hs_s1_d     = w_hs0 ? SYNC_POL : ~SYNC_POL;
        vs_s1_d     = w_vs0 ? SYNC_POL : ~SYNC_POL;
        fs_s1_d     = w_fs0;
        pop_s1_d    = w_rdreq;
        de_d        = de_s1_q;
        hsync_d     = hs_s1_q;
        vsync_d     = vs_s1_q;
        fs_d        = fs_s1_q;
        // Unpopped pixels (underflow or blanking) are forced black
        rgb_d       = pop_s1_q ? bus.fifo_q[23:0] : 24'd0;
        underflow_d = underflow_q | (w_active & bus.fifo_empty);
    end

    // Pipeline registers with idle reset values
    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            de_s1_q     <= 1'b0;
            hs_s1_q     <= ~SYNC_POL;
            vs_s1_q     <= ~SYNC_POL;
            fs_s1_q     <= 1'b0;
            pop_s1_q    <= 1'b0;
            de_q        <= 1'b0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            fs_q        <= 1'b0;
            rgb_q       <= 24'd0;
            underflow_q <= 1'b0;
        end else begin
            de_s1_q     <= de_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            fs_s1_q     <= fs_s1_d;
            pop_s1_q    <= pop_s1_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            fs_q        <= fs_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.read_init   = w_read_init;
    assign bus.fifo_rdreq  = w_rdreq;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = fs_q;
    assign bus.r           = rgb_q[23:16];
    assign bus.g           = rgb_q[15:8];
    assign bus.b           = rgb_q[7:0];
    assign bus.underflow   = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_dvi_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvi_frame_reader
// Brief    : Self-checking bench for dvi_frame_reader using a reduced raster
//            (16x8 total, 8x4 active), a word-counting FIFO and a
//            position-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvi_frame_reader;
    localparam int   HA  = 8;
    localparam int   HFP = 2;
    localparam int   HS  = 3;
    localparam int   HB  = 3;
    localparam int   HT  = HA + HFP + HS + HB;
    localparam int   VA  = 4;
    localparam int   VFP = 1;
    localparam int   VS  = 2;
    localparam int   VB  = 1;
    localparam int   VT  = VA + VFP + VS + VB;
    localparam int   FR  = HT * VT;
    localparam int   PL  = 64;
    localparam logic POL = 1'b0;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    localparam exp_t C_IDLE_E = '{de: 1'b0, hs: ~POL, vs: ~POL, fs: 1'b0, rgb: 24'd0};

    logic clk = 1'b0;
    logic rst;
    dvi_frame_reader_if bus ();

    dvi_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .PRIME_LEVEL(PL)
    ) dut (
        .dvi_clk (clk),
        .reset   (rst),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Normal-mode FIFO: a pop loads the next word of the 1,2,3... stream onto q
    logic [31:0] word_ctr = 32'd1;
    always @(posedge clk) begin
        if (bus.fifo_rdreq) begin
            bus.fifo_q <= word_ctr;
            word_ctr   <= word_ctr + 32'd1;
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          m_mode;   // 0 idle, 1 priming, 2 displaying
    int          m_pos;    // cycles into the current frame while displaying
    logic        m_uf;
    logic [31:0] m_word = 32'd1;
    exp_t        e_d1, e_d2, e0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check current outputs, predict this cycle's stage-0, advance across the edge
    task automatic tick();
        int   h, v;
        logic act, run, exp_rd;
        #1;
        chk("de",          {31'd0, bus.de},          {31'd0, e_d2.de});
        chk("hsync",       {31'd0, bus.hsync},       {31'd0, e_d2.hs});
        chk("vsync",       {31'd0, bus.vsync},       {31'd0, e_d2.vs});
        chk("frame_start", {31'd0, bus.frame_start}, {31'd0, e_d2.fs});
        chk("rgb",         {8'd0, bus.r, bus.g, bus.b}, {8'd0, e_d2.rgb});
        chk("underflow",   {31'd0, bus.underflow},   {31'd0, m_uf});
        chk("read_init",   {31'd0, bus.read_init},   {31'd0, (m_mode != 0)});

        run    = (m_mode == 2);
        h      = m_pos % HT;
        v      = m_pos / HT;
        act    = run && (h < HA) && (v < VA);
        exp_rd = act && !bus.fifo_empty;
        chk("rdreq", {31'd0, bus.fifo_rdreq}, {31'd0, exp_rd});

        e0.de  = act;
        e0.hs  = (run && h >= HA + HFP && h < HA + HFP + HS) ? POL : ~POL;
        e0.vs  = (run && v >= VA + VFP && v < VA + VFP + VS) ? POL : ~POL;
        e0.fs  = run && (m_pos == 0);
        e0.rgb = 24'd0;
        if (exp_rd) begin
            e0.rgb = m_word[23:0];
            m_word = m_word + 32'd1;
        end
        e_d2 = e_d1;
        e_d1 = e0;

        if (rst) begin
            m_mode = 0;
            m_pos  = 0;
            m_uf   = 1'b0;
            e_d1   = C_IDLE_E;
            e_d2   = C_IDLE_E;
        end else begin
            m_uf = m_uf | (act & bus.fifo_empty);
            case (m_mode)
                0: if (bus.enable) m_mode = 1;
                1: if (int'(bus.fifo_rdusedw) >= PL) begin m_mode = 2; m_pos = 0; end
                default: begin
                    if (m_pos == FR - 1) begin
                        m_pos = 0;
                        if (!bus.enable) m_mode = 0;
                    end else begin
                        m_pos++;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.enable       = 1'b0;
        bus.fifo_empty   = 1'b0;
        bus.fifo_rdusedw = 9'd0;
        m_mode = 0;
        m_pos  = 0;
        m_uf   = 1'b0;
        e_d1   = C_IDLE_E;
        e_d2   = C_IDLE_E;
        @(posedge clk);
        #1;

        // Reset held, then idle with enable low
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Priming below threshold: read_init high, nothing popped
        bus.enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.fifo_rdusedw = 9'($urandom_range(0, PL - 1));
            tick();
        end

        // Threshold reached: one clean frame plus a bit, random fill levels during RUN
        bus.fifo_rdusedw = 9'($urandom_range(PL, 511));
        tick();
        for (int i = 0; i < FR + 5; i++) begin
            bus.fifo_rdusedw = 9'($urandom_range(0, 511));
            tick();
        end

        // Five-cycle empty burst in the middle of an active line
        for (int i = 0; i < 2 * FR; i++) begin
            bus.fifo_empty = (m_mode == 2) && (m_pos / HT == 1) &&
                             (m_pos % HT >= 2) && (m_pos % HT <= 6);
            tick();
        end

        // Random empties over a further frame
        for (int i = 0; i < FR; i++) begin
            bus.fifo_empty = ($urandom_range(0, 5) == 0);
            tick();
        end
        bus.fifo_empty = 1'b0;

        // Mid-frame reset for three cycles, then idle checks
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst        = 1'b0;
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Restart, then drop enable mid-frame: frame completes, then idle
        bus.enable       = 1'b1;
        bus.fifo_rdusedw = 9'($urandom_range(PL, 511));
        for (int i = 0; i < FR / 2 + 3; i++) tick();
        bus.enable = 1'b0;
        for (int i = 0; i < FR + 20; i++) begin
            bus.fifo_rdusedw = 9'($urandom_range(PL, 511));
            bus.fifo_empty   = ($urandom_range(0, 7) == 0);
            tick();
        end
        bus.fifo_empty = 1'b0;

        // Re-enable: priming again, then display resumes
        bus.enable = 1'b1;
        for (int i = 0; i < 40; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
